sap_microsequencer: RTL
=======================

Name: sap_microsequencer

Overview:
- Parametrised successor to the SAP-1 fixed five-step controller.
- Sequences fetch and execute micro-steps from the IR opcode and drives the packed control word for the bus datapath.
- Adds over the previous generation:
  - variable-length instructions (early end of cycle);
  - conditional jumps on zero and carry flags;
  - memory wait-state handshake;
  - sticky halt.

Parameters:
- OPCODE_W, 4, width of instrucao.
- STEP_W, 3, width of the step counter; must satisfy 2^STEP_W >= MAX_STEPS.
- MAX_STEPS, 5, last legal step index + 1; a step reaching MAX_STEPS-1 always ends the instruction.
- CTRL_W, 18, control word width (bit map in package).

Ports:
- clock  in  1  system clock; all state updates on falling edge, datapath samples on rising edge.
- reset  in  1  synchronous, active-high.
- instrucao  in  OPCODE_W  opcode from IR (upper bits).
- zero_flag  in  1  accumulator == 0, registered in datapath.
- carry_flag  in  1  carry/borrow from last ADD/SUB.
- mem_ready  in  1  RAM can complete an access this step.
- ctrl  out  CTRL_W  packed control word: PC_OUT, PC_INC, JMP, ACC_IN, ACC_OUT, MAR_IN, RAM_OUT, RAM_IN, ALU_OUT, ADD_SUB, XOR_NOT, ALU0, ALU1, BR_IN, OPR_IN, IR_IN, IR_OUT, HLT.
- step  out  STEP_W  current micro-step (debug/trace).
- instr_done  out  1  one-cycle pulse with the final step of each instruction.
- halted  out  1  sticky halt indicator.

Behaviour:
- Reset (sampled at a falling edge): step=0, ctrl=0, instr_done=0, halted=0.
  - Applies mid-instruction and while halted; the next issued word is fetch step T0.
- Fetch:
  - T0: PC_OUT|MAR_IN.
  - T1: RAM_OUT|IR_IN|PC_INC.
- Execute steps T2..T4, opcode map:
  - 0001 LDA: T2 IR_OUT|MAR_IN; T3 RAM_OUT|ACC_IN (end).
  - 0010 LDI: T2 IR_OUT|ACC_IN (end).
  - 0011 STA: T2 IR_OUT|MAR_IN; T3 ACC_OUT|RAM_IN (end).
  - 0100 ADD / 0101 SUB:
    - T2 IR_OUT|MAR_IN; T3 RAM_OUT|BR_IN.
    - T4 ALU_OUT|ACC_IN (SUB also ADD_SUB) (end).
  - 0110 AND / 0111 OR / 1000 XOR:
    - Same T2/T3 as ADD.
    - T4 ALU_OUT|RAM_IN with ALU0 / ALU1 / ALU0|ALU1 respectively (end).
  - 1001 NOT: T2 ALU_OUT|ACC_IN|ALU1|ALU0|XOR_NOT (end).
  - 1010 JMP: T2 IR_OUT|JMP (end).
  - 1011 JZ: T2 IR_OUT|JMP if zero_flag=1, else all-zero word (end either way).
  - 1100 JC: as JZ, using carry_flag.
  - 1110 OUT: T2 ACC_OUT|OPR_IN (end).
  - 1111 HLT: T2 HLT (end); halted=1 from the same edge.
  - 0000 NOP and 1101 undefined: T2 all-zero word (end).
- Flags are sampled at the falling edge that issues T2.
- End handling:
  - On an end step, instr_done=1 with that word.
  - Step returns to 0 at the next edge; no idle steps are padded.
  - Cycle counts: LDI/JMP/NOP/OUT/NOT = 3; LDA/STA = 4; ALU ops = 5.
- Wait states:
  - Applies when the word about to be issued contains RAM_OUT or RAM_IN and mem_ready=0 at that edge.
  - Issue a wait word instead: the real word with ACC_IN, BR_IN, IR_IN, MAR_IN, OPR_IN, RAM_IN, PC_INC, JMP forced 0.
  - Step is not advanced; instr_done=0.
  - Retry every falling edge; the full word is issued on the first edge with mem_ready=1.
  - No cap on wait length.
- Halt:
  - While halted=1: ctrl=0 except HLT=1, step frozen, inputs ignored until reset.
- Width rules:
  - Opcodes are compared at full OPCODE_W; upper bits beyond 4 must be zero, else the opcode decodes as NOP.
  - Step wraps to 0 only via end or reset, never by overflow.

Decomposition:
- Package sap_pkg holds:
  - opcode localparams (OP_LDA ... OP_HLT);
  - CTRL bit-index localparams;
  - LOAD_MASK (bits cleared in wait words);
  - RAM_MASK (RAM_OUT|RAM_IN).
- One sub-module, sap_microcode_rom: combinational (opcode, step, zero_flag, carry_flag) -> {ctrl_word, end_flag}.
- sap_microsequencer holds the step register, wait/halt logic and output registers.

Test Plan:
- Reset, then LDA (0001) with mem_ready=1 -> 4 words T0..T3 as mapped; instr_done high only on T3; step back to 0 on the 5th edge.
- SUB (0101), mem_ready=0 for 2 edges at T3 -> two wait words containing RAM_OUT only; then RAM_OUT|BR_IN; then ALU_OUT|ACC_IN|ADD_SUB; total 7 cycles.
- JZ (1011):
  - zero_flag=1 -> T2 = IR_OUT|JMP.
  - zero_flag=0 -> T2 = 0.
  - 3 cycles in both cases.
- HLT (1111) -> HLT asserted and halted=1 at T2; ctrl stays HLT for 10 further edges despite opcode changes; reset -> T0 word PC_OUT|MAR_IN.
- Reset asserted during T3 of ADD -> next word ctrl=0 with step=0, then fetch T0; no ACC_IN is ever issued.
- Opcode 1101 -> 3-cycle instruction with zero T2 word and instr_done pulse.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP microsequencer: opcodes, control-word bit map,
// masks used for memory wait words and the sequencer state type.
package sap_pkg;

    localparam int CTRL_BITS = 18;

    // Control word bit positions, MSB first in the order the datapath lists them.
    localparam int C_PC_OUT  = 17;
    localparam int C_PC_INC  = 16;
    localparam int C_JMP     = 15;
    localparam int C_ACC_IN  = 14;
    localparam int C_ACC_OUT = 13;
    localparam int C_MAR_IN  = 12;
    localparam int C_RAM_OUT = 11;
    localparam int C_RAM_IN  = 10;
    localparam int C_ALU_OUT = 9;
    localparam int C_ADD_SUB = 8;
    localparam int C_XOR_NOT = 7;
    localparam int C_ALU0    = 6;
    localparam int C_ALU1    = 5;
    localparam int C_BR_IN   = 4;
    localparam int C_OPR_IN  = 3;
    localparam int C_IR_IN   = 2;
    localparam int C_IR_OUT  = 1;
    localparam int C_HLT     = 0;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_LDI = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_JZ  = 4'b1011;
    localparam logic [3:0] OP_JC  = 4'b1100;
    localparam logic [3:0] OP_UND = 4'b1101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef logic [CTRL_BITS-1:0] ctrlWord_t;

    function automatic ctrlWord_t ctrlBit(input int idx);
        return ctrlWord_t'(1) << idx;
    endfunction

    // Every register-load strobe; a wait word keeps only the drive/ALU bits.
    localparam ctrlWord_t LOAD_MASK = (ctrlWord_t'(1) << C_ACC_IN) | (ctrlWord_t'(1) << C_BR_IN)
                                    | (ctrlWord_t'(1) << C_IR_IN)  | (ctrlWord_t'(1) << C_MAR_IN)
                                    | (ctrlWord_t'(1) << C_OPR_IN) | (ctrlWord_t'(1) << C_RAM_IN)
                                    | (ctrlWord_t'(1) << C_PC_INC) | (ctrlWord_t'(1) << C_JMP);
    localparam ctrlWord_t RAM_MASK  = (ctrlWord_t'(1) << C_RAM_OUT) | (ctrlWord_t'(1) << C_RAM_IN);

    typedef enum logic {SEQ_RUN, SEQ_HALT} seqState_t;

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> control word and end-of-instruction flag.
module sap_microcode_rom
    import sap_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int STEP_W    = 3,
    parameter int MAX_STEPS = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    input  logic                zero_flag,
    input  logic                carry_flag,
    output ctrlWord_t           ctrl_word,
    output logic                end_flag
);

    logic tableEnd;

    // Opcodes compare at full width, so any set bit above the 4-bit map falls to NOP.
    always_comb begin
        ctrl_word = '0;
        tableEnd  = 1'b0;
        case (step)
            STEP_W'(0): ctrl_word = ctrlBit(C_PC_OUT) | ctrlBit(C_MAR_IN);
            STEP_W'(1): ctrl_word = ctrlBit(C_RAM_OUT) | ctrlBit(C_IR_IN) | ctrlBit(C_PC_INC);
            STEP_W'(2): begin
                case (opcode)
                    OPCODE_W'(OP_LDA), OPCODE_W'(OP_STA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB),
                    OPCODE_W'(OP_AND), OPCODE_W'(OP_OR), OPCODE_W'(OP_XOR):
                        ctrl_word = ctrlBit(C_IR_OUT) | ctrlBit(C_MAR_IN);
                    OPCODE_W'(OP_LDI): begin
                        ctrl_word = ctrlBit(C_IR_OUT) | ctrlBit(C_ACC_IN);
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_NOT): begin
                        ctrl_word = ctrlBit(C_ALU_OUT) | ctrlBit(C_ACC_IN) | ctrlBit(C_ALU1)
                                  | ctrlBit(C_ALU0) | ctrlBit(C_XOR_NOT);
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_JMP): begin
                        ctrl_word = ctrlBit(C_IR_OUT) | ctrlBit(C_JMP);
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_JZ): begin
                        ctrl_word = zero_flag ? (ctrlBit(C_IR_OUT) | ctrlBit(C_JMP)) : '0;
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_JC): begin
                        ctrl_word = carry_flag ? (ctrlBit(C_IR_OUT) | ctrlBit(C_JMP)) : '0;
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_OUT): begin
                        ctrl_word = ctrlBit(C_ACC_OUT) | ctrlBit(C_OPR_IN);
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_HLT): begin
                        ctrl_word = ctrlBit(C_HLT);
                        tableEnd  = 1'b1;
                    end
                    default: tableEnd = 1'b1;
                endcase
            end
            STEP_W'(3): begin
                case (opcode)
                    OPCODE_W'(OP_LDA): begin
                        ctrl_word = ctrlBit(C_RAM_OUT) | ctrlBit(C_ACC_IN);
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_STA): begin
                        ctrl_word = ctrlBit(C_ACC_OUT) | ctrlBit(C_RAM_IN);
                        tableEnd  = 1'b1;
                    end
                    OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND),
                    OPCODE_W'(OP_OR), OPCODE_W'(OP_XOR):
                        ctrl_word = ctrlBit(C_RAM_OUT) | ctrlBit(C_BR_IN);
                    default: tableEnd = 1'b1;
                endcase
            end
            STEP_W'(4): begin
                tableEnd = 1'b1;
                case (opcode)
                    OPCODE_W'(OP_ADD): ctrl_word = ctrlBit(C_ALU_OUT) | ctrlBit(C_ACC_IN);
                    OPCODE_W'(OP_SUB): ctrl_word = ctrlBit(C_ALU_OUT) | ctrlBit(C_ACC_IN) | ctrlBit(C_ADD_SUB);
                    OPCODE_W'(OP_AND): ctrl_word = ctrlBit(C_ALU_OUT) | ctrlBit(C_RAM_IN) | ctrlBit(C_ALU0);
                    OPCODE_W'(OP_OR):  ctrl_word = ctrlBit(C_ALU_OUT) | ctrlBit(C_RAM_IN) | ctrlBit(C_ALU1);
                    OPCODE_W'(OP_XOR): ctrl_word = ctrlBit(C_ALU_OUT) | ctrlBit(C_RAM_IN)
                                                 | ctrlBit(C_ALU0) | ctrlBit(C_ALU1);
                    default: ctrl_word = '0;
                endcase
            end
            default: tableEnd = 1'b1;
        endcase
        end_flag = tableEnd || (step >= STEP_W'(MAX_STEPS - 1));
    end

endmodule

// File: rtl/sap_microsequencer.sv
// Step sequencer for the SAP bus datapath: issues one registered control word per falling edge,
// stretching RAM steps with wait words and latching a sticky halt.
module sap_microsequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int STEP_W    = 3,
    parameter int MAX_STEPS = 5,
    parameter int CTRL_W    = 18
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] instrucao,
    input  logic                zero_flag,
    input  logic                carry_flag,
    input  logic                mem_ready,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [STEP_W-1:0]   step,
    output logic                instr_done,
    output logic                halted
);

    seqState_t         state_q, state_d;
    logic [STEP_W-1:0] issueStep_q, issueStep_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              done_q, done_d;

    ctrlWord_t romWord;
    logic      romEnd;
    logic      needWait;

    sap_microcode_rom #(
        .OPCODE_W  (OPCODE_W),
        .STEP_W    (STEP_W),
        .MAX_STEPS (MAX_STEPS)
    ) u_rom (
        .opcode     (instrucao),
        .step       (issueStep_q),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .ctrl_word  (romWord),
        .end_flag   (romEnd)
    );

    assign needWait = (|(romWord & RAM_MASK)) && !mem_ready;

    // issueStep_q is the step the next edge will issue; step_q is what is on the bus now.
    always_comb begin
        state_d     = state_q;
        issueStep_d = issueStep_q;
        ctrl_d      = ctrl_q;
        step_d      = step_q;
        done_d      = 1'b0;
        case (state_q)
            SEQ_RUN: begin
                step_d = issueStep_q;
                if (needWait) begin
                    ctrl_d = CTRL_W'(romWord & ~LOAD_MASK);
                end else begin
                    ctrl_d      = CTRL_W'(romWord);
                    done_d      = romEnd;
                    issueStep_d = romEnd ? '0 : issueStep_q + STEP_W'(1);
                    if (romWord[C_HLT]) begin
                        state_d = SEQ_HALT;
                    end
                end
            end
            SEQ_HALT: ctrl_d = CTRL_W'(ctrlBit(C_HLT));
            default:  state_d = SEQ_RUN;
        endcase
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state_q     <= SEQ_RUN;
            issueStep_q <= '0;
            ctrl_q      <= '0;
            step_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issueStep_q <= issueStep_d;
            ctrl_q      <= ctrl_d;
            step_q      <= step_d;
            done_q      <= done_d;
        end
    end

    assign ctrl       = ctrl_q;
    assign step       = step_q;
    assign instr_done = done_q;
    assign halted     = (state_q == SEQ_HALT);

endmodule
